// File: rtl/axi4_lite_ram_slave_pkg.sv
// Shared types for the AXI4-Lite RAM slave: response codes and the write/read FSM encodings.
package axi4_lite_Defs;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_WRITE = 2'd1,
    W_RESP  = 2'd2
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_READ = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

endpackage

// File: rtl/axi4_lite_ram_slave_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels) with master and slave views.
interface axi4_lite_ram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_ram_slave_ram.sv
// Simple dual-port RAM: byte-enabled write port and registered read port (read-before-write).
module axi4_lite_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_we,
  input  logic [$clog2(DEPTH)-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
  input  logic                      i_rd_en,
  input  logic                      i_rd_zero,
  input  logic [$clog2(DEPTH)-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0]     o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Output register holds its value between reads so RDATA stays stable while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= {DATA_WIDTH{1'b0}};
    end else if (i_rd_en) begin
      r_rdata <= i_rd_zero ? {DATA_WIDTH{1'b0}} : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite memory slave with independent AW/W capture, WSTRB writes and registered handshakes.
// Define AXI4L_RANGE_CHECK_EN to answer word indices >= DEPTH with SLVERR instead of aliasing.
module axi4_lite_ram_slave
  import axi4_lite_Defs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input logic                  ACLK,
  input logic                  ARESET,
  axi4_lite_ram_slave_if.slave s_axi
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef AXI4L_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (OFFS + IDX_W)) != {ADDR_WIDTH{1'b0}};
  endfunction

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;
  logic r_aw_held, r_w_held, w_aw_held_nxt, w_w_held_nxt;
  logic r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic w_awready_nxt, w_wready_nxt, w_bvalid_nxt, w_arready_nxt, w_rvalid_nxt;
  resp_t r_bresp, r_rresp, w_bresp_nxt, w_rresp_nxt;
  logic [IDX_W-1:0] r_aw_idx, r_ar_idx;
  logic r_aw_err, r_ar_err;
  logic [DATA_WIDTH-1:0] r_wdata, w_rdata;
  logic [NB-1:0] r_wstrb;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_ram_we, w_ram_re;

  assign w_aw_hs = s_axi.AWVALID & r_awready;
  assign w_w_hs  = s_axi.WVALID & r_wready;
  assign w_ar_hs = s_axi.ARVALID & r_arready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  // Range is judged at capture time so only the word index needs to be held.
  always_ff @(posedge ACLK) begin
    if (w_aw_hs) begin
      r_aw_idx <= s_axi.AWADDR[OFFS +: IDX_W];
      r_aw_err <= RANGE_CHK & addr_err(s_axi.AWADDR);
    end
    if (w_w_hs) begin
      r_wdata <= s_axi.WDATA;
      r_wstrb <= s_axi.WSTRB;
    end
    if (w_ar_hs) begin
      r_ar_idx <= s_axi.ARADDR[OFFS +: IDX_W];
      r_ar_err <= RANGE_CHK & addr_err(s_axi.ARADDR);
    end
  end

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    case (r_wstate)
      W_IDLE: begin
        w_aw_held_nxt = r_aw_held | w_aw_hs;
        w_w_held_nxt  = r_w_held | w_w_hs;
        if (w_aw_held_nxt && w_w_held_nxt) w_wstate_nxt = W_WRITE;
        else                               w_wstate_nxt = W_IDLE;
      end
      W_WRITE: w_wstate_nxt = W_RESP;
      W_RESP: begin
        if (r_bvalid && s_axi.BREADY) begin
          w_wstate_nxt  = W_IDLE;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
        end else begin
          w_wstate_nxt = W_RESP;
        end
      end
      default: begin
        w_wstate_nxt  = W_IDLE;
        w_aw_held_nxt = 1'b0;
        w_w_held_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_awready_nxt = (w_wstate_nxt == W_IDLE) & ~w_aw_held_nxt;
    w_wready_nxt  = (w_wstate_nxt == W_IDLE) & ~w_w_held_nxt;
    w_bvalid_nxt  = (w_wstate_nxt == W_RESP);
    w_ram_we      = (r_wstate == W_WRITE) & ~r_aw_err;
    if (r_wstate == W_WRITE) w_bresp_nxt = r_aw_err ? SLVERR : OKAY;
    else                     w_bresp_nxt = r_bresp;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) w_rstate_nxt = R_READ;
        else         w_rstate_nxt = R_IDLE;
      end
      R_READ: w_rstate_nxt = R_DATA;
      R_DATA: begin
        if (r_rvalid && s_axi.RREADY) w_rstate_nxt = R_IDLE;
        else                          w_rstate_nxt = R_DATA;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_arready_nxt = (w_rstate_nxt == R_IDLE);
    w_rvalid_nxt  = (w_rstate_nxt == R_DATA);
    w_ram_re      = (r_rstate == R_READ);
    if (r_rstate == R_READ) w_rresp_nxt = r_ar_err ? SLVERR : OKAY;
    else                    w_rresp_nxt = r_rresp;
  end

  axi4_lite_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_we      (w_ram_we),
    .i_waddr   (r_aw_idx),
    .i_wdata   (r_wdata),
    .i_wstrb   (r_wstrb),
    .i_rd_en   (w_ram_re),
    .i_rd_zero (r_ar_err),
    .i_raddr   (r_ar_idx),
    .o_rdata   (w_rdata)
  );

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;
  assign s_axi.ARREADY = r_arready;
  assign s_axi.RVALID  = r_rvalid;
  assign s_axi.RRESP   = r_rresp;
  assign s_axi.RDATA   = w_rdata;
endmodule
